// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result accumulator: ALU kind encodings and FSM states.
package alu_pkg;

  localparam int ALU_KIND_XNOR = 0;
  localparam int ALU_KIND_MUL  = 1;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_RUN,
    ACC_DONE
  } acc_state_t;

endpackage

// File: rtl/popcnt_unit.sv
// Combinational population count of a DATA_WIDTH-bit word.
module popcnt_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic [CNT_W-1:0]      count
);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      count = count + CNT_W'(data[i]);
    end
  end

endmodule

// File: rtl/acc_unit.sv
// Accumulates VEC_LEN ALU result beats into one signed dot-product result with a
// valid/ready output handshake.
module acc_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ALU_KIND   = 0,
  parameter int VEC_LEN    = 16,
  parameter int ACC_WIDTH  = 48
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ACC_WIDTH-1:0]  out_data_o,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(VEC_LEN);
  localparam int PC_W  = $clog2(DATA_WIDTH + 1);

  acc_state_t           state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] term;
  logic [ACC_WIDTH-1:0] sum;
  logic                 accept;
  logic                 last;

  generate
    if (ALU_KIND == ALU_KIND_XNOR) begin : g_xnor
      logic [PC_W-1:0] ones;
      popcnt_unit #(
        .DATA_WIDTH(DATA_WIDTH),
        .CNT_W     (PC_W)
      ) u_popcnt (
        .data (in_data_i),
        .count(ones)
      );
      // 2*ones - DATA_WIDTH evaluated modulo 2^ACC_WIDTH yields the signed term
      assign term = (ACC_WIDTH'(ones) << 1) - ACC_WIDTH'(DATA_WIDTH);
    end else if (ALU_KIND == ALU_KIND_MUL) begin : g_mul
      assign term = ACC_WIDTH'(signed'(in_data_i));
    end else begin : g_null
      logic unused_data;
      assign unused_data = ^in_data_i;
      assign term        = '0;
    end
  endgenerate

  assign in_ready_o  = (state != ACC_DONE);
  assign out_valid_o = (state == ACC_DONE);
  assign busy_o      = (state != ACC_IDLE);
  assign accept      = in_valid_i && in_ready_o;
  assign last        = (cnt == CNT_W'(VEC_LEN - 1));
  assign sum         = (state == ACC_IDLE) ? term : acc + term;

  always_comb begin
    state_next = state;
    case (state)
      ACC_IDLE: if (accept)              state_next = ACC_RUN;
      ACC_RUN:  if (accept && last)      state_next = ACC_DONE;
      ACC_DONE: if (out_ready_i)         state_next = ACC_IDLE;
      default:                           state_next = ACC_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= ACC_IDLE;
      cnt        <= '0;
      acc        <= '0;
      out_data_o <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        acc <= sum;
        cnt <= last ? '0 : cnt + CNT_W'(1);
        if (last) out_data_o <= sum;
      end
    end
  end

endmodule

// File: tb/tb_acc_unit.sv
// Randomized and directed bench for acc_unit: four instances (XNOR, MUL, MUL with
// 8-bit accumulator, null) share stimulus and are checked against a queue-based model.
module tb_acc_unit;

  localparam int DW  = 8;
  localparam int VL  = 4;
  localparam int AW  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;

  logic          rdy0, rdy1, rdy2, rdy3;
  logic          vld0, vld1, vld2, vld3;
  logic          bsy0, bsy1, bsy2, bsy3;
  logic [AW-1:0] d0, d1, d3;
  logic [7:0]    d2;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // reference model state
  logic [DW-1:0] q[$];
  bit            pending = 0;
  logic [15:0]   r0 = '0, r1 = '0, r3 = '0;
  logic [7:0]    r2 = '0;

  always #5 clk = ~clk;

  acc_unit #(.DATA_WIDTH(DW), .ALU_KIND(0), .VEC_LEN(VL), .ACC_WIDTH(AW)) u0 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy0),
    .in_data_i(in_data), .out_valid_o(vld0), .out_ready_i(out_ready),
    .out_data_o(d0), .busy_o(bsy0));

  acc_unit #(.DATA_WIDTH(DW), .ALU_KIND(1), .VEC_LEN(VL), .ACC_WIDTH(AW)) u1 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy1),
    .in_data_i(in_data), .out_valid_o(vld1), .out_ready_i(out_ready),
    .out_data_o(d1), .busy_o(bsy1));

  acc_unit #(.DATA_WIDTH(DW), .ALU_KIND(1), .VEC_LEN(VL), .ACC_WIDTH(8)) u2 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy2),
    .in_data_i(in_data), .out_valid_o(vld2), .out_ready_i(out_ready),
    .out_data_o(d2), .busy_o(bsy2));

  acc_unit #(.DATA_WIDTH(DW), .ALU_KIND(2), .VEC_LEN(VL), .ACC_WIDTH(AW)) u3 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy3),
    .in_data_i(in_data), .out_valid_o(vld3), .out_ready_i(out_ready),
    .out_data_o(d3), .busy_o(bsy3));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compute_result();
    int s0 = 0;
    int s1 = 0;
    foreach (q[i]) begin
      s0 += 2 * $countones(q[i]) - DW;
      s1 += int'($signed(q[i]));
    end
    r0 = 16'(s0);
    r1 = 16'(s1);
    r2 = 8'(s1);
    r3 = '0;
  endtask

  task automatic model_edge();
    if (pending) begin
      if (out_ready) pending = 0;
    end else if (in_valid) begin
      q.push_back(in_data);
      if (q.size() == VL) begin
        compute_result();
        pending = 1;
        q.delete();
      end
    end
  endtask

  task automatic compare_all();
    bit busy_exp;
    busy_exp = pending || (q.size() != 0);
    check("in_ready_k0", rdy0, !pending);
    check("in_ready_null", rdy3, !pending);
    check("out_valid_k0", vld0, pending);
    check("out_valid_k1", vld1, pending);
    check("out_valid_k1w8", vld2, pending);
    check("out_valid_null", vld3, pending);
    check("busy_k0", bsy0, busy_exp);
    check("busy_k1w8", bsy2, busy_exp);
    check("data_k0", d0, r0);
    check("data_k1", d1, r1);
    check("data_k1w8", d2, r2);
    check("data_null", d3, r3);
  endtask

  task automatic tick(input logic v, input logic [DW-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    compare_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic beats4(input logic [DW-1:0] d);
    for (int i = 0; i < VL; i++) tick(1'b1, d, 1'b1);
  endtask

  task automatic expect_result(input logic [15:0] e0, input logic [15:0] e1, input logic [7:0] e2);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("res_valid", vld0, 1'b1);
    check("res_k0", d0, e0);
    check("res_k1", d1, e1);
    check("res_k1w8", d2, e2);
    check("res_null", d3, 16'h0000);
    compare_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    pending = 0;
    r0 = '0; r1 = '0; r2 = '0; r3 = '0;
    #2;
    check("rst_valid", {vld0, vld1, vld2, vld3}, 4'b0000);
    check("rst_busy", {bsy0, bsy1, bsy2, bsy3}, 4'b0000);
    check("rst_data_k0", d0, 16'h0000);
    check("rst_data_k1", d1, 16'h0000);
    check("rst_data_k1w8", d2, 8'h00);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    apply_reset();
    check("ready_after_rst", {rdy0, rdy1, rdy2, rdy3}, 4'b1111);

    // back-to-back all-ones vector
    beats4(8'hFF);
    expect_result(16'h0020, 16'hFFFC, 8'hFC);

    beats4(8'h00);
    expect_result(16'hFFE0, 16'h0000, 8'h00);
    beats4(8'h0F);
    expect_result(16'h0000, 16'h003C, 8'h3C);

    // bubbles between beats must not count
    tick(1'b1, 8'h03, 1'b1); tick(1'b0, 8'hAA, 1'b1);
    tick(1'b1, 8'hFE, 1'b1); tick(1'b0, 8'h55, 1'b1); tick(1'b0, 8'hFF, 1'b1);
    tick(1'b1, 8'h05, 1'b1); tick(1'b0, 8'h11, 1'b1);
    tick(1'b1, 8'h01, 1'b1);
    expect_result(16'hFFF8, 16'h0007, 8'h07);

    // backpressure: result held, incoming beats ignored
    tick(1'b1, 8'h01, 1'b0); tick(1'b1, 8'h02, 1'b0);
    tick(1'b1, 8'h03, 1'b0); tick(1'b1, 8'h04, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 8'h55, 1'b0);
      check("bp_hold_k0", d0, 16'hFFEA);
      check("bp_ready_low", rdy1, 1'b0);
    end
    expect_result(16'hFFEA, 16'h000A, 8'h0A);
    beats4(8'h0F);
    expect_result(16'h0000, 16'h003C, 8'h3C);

    // reset mid-vector discards the partial sum
    tick(1'b1, 8'hFF, 1'b1); tick(1'b1, 8'hFF, 1'b1);
    apply_reset();
    tick(1'b0, 8'h00, 1'b1);
    check("no_stale_result", vld0, 1'b0);
    beats4(8'hFF);
    expect_result(16'h0020, 16'hFFFC, 8'hFC);
    tick(1'b0, 8'h00, 1'b1);
    check("single_result", vld0, 1'b0);

    // wrap-around in the 8-bit accumulator
    beats4(8'h7F);
    expect_result(16'h0018, 16'h01FC, 8'hFC);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) apply_reset();
      tick($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_unit.md
ACC_UNIT -- requirements
Module: acc_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of each ALU result beat.
REQ-002 Parameter ALU_KIND, default 0: 0 = XNOR (binary) mode, 1 = MUL (integer) mode, other values = null mode.
REQ-003 Parameter VEC_LEN, default 16: number of beats accumulated per result; legal range is 2 or more.
REQ-004 Parameter ACC_WIDTH, default 48: width of the signed accumulator and result.
REQ-005 Port clk_i, input, 1: the single clock.
REQ-006 Port rst_n_i, input, 1: asynchronous, active-low reset.
REQ-007 Port in_valid_i, input, 1: an upstream ALU beat is present.
REQ-008 Port in_ready_o, output, 1: the block accepts a beat this cycle.
REQ-009 Port in_data_i, input, DATA_WIDTH: the ALU result c_o.
REQ-010 Port out_valid_o, output, 1: the accumulated result is valid.
REQ-011 Port out_ready_i, input, 1: the downstream block accepts the result.
REQ-012 Port out_data_o, output, ACC_WIDTH: the signed dot-product result.
REQ-013 Port busy_o, output, 1: high when the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have three states:
- IDLE -> ACC on the first accepted beat.
- ACC -> DONE on acceptance of beat number VEC_LEN.
- DONE -> IDLE on out_valid_o && out_ready_i.
REQ-015 A beat SHALL be accepted only when in_valid_i && in_ready_o are both high; cycles with in_valid_i low (bubbles) SHALL change nothing.
REQ-016 in_ready_o SHALL be high in IDLE and ACC, and low in DONE.
REQ-017 The per-beat term SHALL depend on ALU_KIND:
- ALU_KIND=0: term = 2*popcount(in_data_i) - DATA_WIDTH, signed.
- ALU_KIND=1: term = in_data_i, sign-extended to ACC_WIDTH.
- Any other value: term = 0.
REQ-018 On the first beat of a vector the accumulator SHALL load the term; on later beats it SHALL load acc + term.
REQ-019 Accumulation SHALL use two's-complement arithmetic that wraps modulo 2^ACC_WIDTH, with no saturation.
REQ-020 A 0..VEC_LEN-1 beat counter SHALL increment on each accepted beat and wrap to 0 on the last beat.
REQ-021 out_valid_o SHALL rise in the cycle after the last beat is accepted, so latency is 1 cycle.
REQ-022 out_data_o SHALL be registered and SHALL hold the final sum stable while out_valid_o is high and out_ready_i is low.
REQ-023 out_valid_o SHALL fall in the cycle after the handshake completes.
REQ-024 The next vector's first beat SHALL be accepted no earlier than the cycle after the handshake, giving a minimum period of VEC_LEN+1 cycles per result.
REQ-025 out_data_o SHALL keep its last value after the handshake until the next result is loaded.

Reset
REQ-026 While rst_n_i is low, the block SHALL asynchronously force:
- state = IDLE, counter = 0, accumulator = 0;
- out_valid_o = 0, out_data_o = 0, busy_o = 0;
- in_ready_o = 1 immediately after release.
REQ-027 A reset asserted mid-vector or in DONE SHALL discard the partial or pending result, and no out_valid_o pulse SHALL follow.
REQ-028 The first beat accepted after reset release SHALL count as beat 1 of a fresh vector.

Structure
REQ-029 Package alu_pkg SHALL hold:
- the ALU_KIND encodings ALU_KIND_XNOR=0 and ALU_KIND_MUL=1;
- the FSM enum acc_state_t {ACC_IDLE, ACC_RUN, ACC_DONE}.
REQ-030 Population count SHALL be a separate combinational sub-module popcnt_unit with parameter DATA_WIDTH, instantiated only when ALU_KIND=0 via a generate branch.
REQ-031 The counter width SHALL be $clog2(VEC_LEN).

Verification (bench config: DATA_WIDTH=8, VEC_LEN=4, ACC_WIDTH=16)
REQ-032 KIND0, four beats of 8'hFF back-to-back -> out_data_o = 32, with out_valid_o high in the cycle after beat 4.
REQ-033 KIND0, beats 8'h00 x4 -> out_data_o = -32 (16'hFFE0); then beats 8'h0F x4 -> out_data_o = 0.
REQ-034 KIND1, beats 3, 8'hFE, 5, 1 with bubbles between beats -> out_data_o = 7, with bubbles not counted as beats.
REQ-035 Backpressure: result ready and out_ready_i held low for 5 cycles -> out_valid_o and out_data_o stay stable, in_ready_o stays low, and in_valid_i beats are ignored; after the handshake the next vector sums correctly.
REQ-036 Reset pulse after 2 accepted beats, then four beats of 8'hFF (KIND0) -> exactly one result, equal to 32.
REQ-037 KIND1, beats 8'h7F x4 with ACC_WIDTH=8 -> out_data_o = 8'hFC, confirming wrap-around.
